// File: rtl/bcd_time_register_pkg.sv
// bcd_time_register_pkg: shared BCD digit width, default field moduli and the noon constant.
package bcd_time_register_pkg;
   localparam int DIGIT_W  = 4;
   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HOUR_MAX = 23;
   localparam int NOON     = 12;
   function automatic logic [7:0] bcd_value(input logic [DIGIT_W-1:0] msd, input logic [DIGIT_W-1:0] lsd);
      return 8'(msd) * 8'd10 + 8'(lsd);
   endfunction
endpackage

// File: rtl/bcd_time_register_12h_convert.sv
// bcd_12h_convert: maps a canonical 24H BCD count to the displayed digits and pm flag.
module bcd_12h_convert
   import bcd_time_register_pkg::*;
#(
   parameter int HOURS_MODE = 0
) (
   input  logic [DIGIT_W-1:0] cnt_msd,
   input  logic [DIGIT_W-1:0] cnt_lsd,
   input  logic               military_time,
   output logic [DIGIT_W-1:0] data_msd,
   output logic [DIGIT_W-1:0] data_lsd,
   output logic               pm
);
   localparam logic [7:0] NOON_V = 8'(NOON);
   logic [7:0] value, hour_12;
   logic twelve;
   assign value   = bcd_value(cnt_msd, cnt_lsd);
   assign twelve  = (HOURS_MODE != 0) && !military_time;
   // midnight and noon both read 12; afternoon hours fold down by 12
   assign hour_12 = value == 8'd0 ? NOON_V : (value > NOON_V ? value - NOON_V : value);
   assign pm       = (HOURS_MODE != 0) && value >= NOON_V;
   assign data_msd = twelve ? (hour_12 >= 8'd10 ? 4'd1 : 4'd0) : cnt_msd;
   assign data_lsd = twelve ? 4'(hour_12 >= 8'd10 ? hour_12 - 8'd10 : hour_12) : cnt_lsd;
endmodule

// File: rtl/bcd_time_register.sv
// bcd_time_register: two-digit BCD time field with load check, wrap carry and 12H/24H display.
// Define TIME_REG_DEC_EN to make the dec strobe functional.
module bcd_time_register
   import bcd_time_register_pkg::*;
#(
   parameter int MAX_VALUE  = SEC_MAX,
   parameter int HOURS_MODE = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               en,
   input  logic               dec,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_msd,
   input  logic [DIGIT_W-1:0] load_lsd,
   input  logic               military_time,
   output logic [DIGIT_W-1:0] data_msd,
   output logic [DIGIT_W-1:0] data_lsd,
   output logic               pm,
   output logic               carry,
   output logic               load_err
);
   localparam logic [DIGIT_W-1:0] MAX_MSD = 4'(MAX_VALUE / 10);
   localparam logic [DIGIT_W-1:0] MAX_LSD = 4'(MAX_VALUE % 10);
   logic [DIGIT_W-1:0] cnt_msd, cnt_lsd, nxt_msd, nxt_lsd;
   logic at_max, load_ok;
   assign at_max  = cnt_msd == MAX_MSD && cnt_lsd == MAX_LSD;
   assign load_ok = load_lsd <= 4'd9 && bcd_value(load_msd, load_lsd) <= 8'(MAX_VALUE);
`ifndef TIME_REG_DEC_EN
   logic unused_dec;
   assign unused_dec = dec;
`endif
   always_comb begin
      nxt_msd = cnt_msd;
      nxt_lsd = cnt_lsd;
      if (load) begin
         nxt_msd = load_ok ? load_msd : cnt_msd;
         nxt_lsd = load_ok ? load_lsd : cnt_lsd;
      end else if (en) begin
         nxt_msd = at_max ? 4'd0 : (cnt_lsd == 4'd9 ? cnt_msd + 4'd1 : cnt_msd);
         nxt_lsd = at_max ? 4'd0 : (cnt_lsd == 4'd9 ? 4'd0 : cnt_lsd + 4'd1);
      end
`ifdef TIME_REG_DEC_EN
      else if (dec) begin
         nxt_msd = cnt_msd == 4'd0 && cnt_lsd == 4'd0 ? MAX_MSD : (cnt_lsd == 4'd0 ? cnt_msd - 4'd1 : cnt_msd);
         nxt_lsd = cnt_msd == 4'd0 && cnt_lsd == 4'd0 ? MAX_LSD : (cnt_lsd == 4'd0 ? 4'd9 : cnt_lsd - 4'd1);
      end
`endif
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_msd  <= '0;
         cnt_lsd  <= '0;
         carry    <= 1'b0;
         load_err <= 1'b0;
      end else begin
         cnt_msd  <= nxt_msd;
         cnt_lsd  <= nxt_lsd;
         carry    <= !load && en && at_max;
         load_err <= load && !load_ok;
      end
   end
   bcd_12h_convert #(.HOURS_MODE(HOURS_MODE)) u_convert (
      .cnt_msd      (cnt_msd),
      .cnt_lsd      (cnt_lsd),
      .military_time(military_time),
      .data_msd     (data_msd),
      .data_lsd     (data_lsd),
      .pm           (pm)
   );
endmodule

// File: tb/tb_bcd_time_register.sv
// tb_bcd_time_register: hours and minutes instances against an arithmetic time-field model.
module tb_bcd_time_register;
`ifdef TIME_REG_DEC_EN
   localparam bit DEC_ON = 1'b1;
`else
   localparam bit DEC_ON = 1'b0;
`endif
   logic clk = 1'b0, reset_n = 1'b0, mil = 1'b0;
   logic h_en = 0, h_dec = 0, h_load = 0, m_en = 0, m_dec = 0, m_load = 0;
   logic [3:0] h_lm = 0, h_ll = 0, m_lm = 0, m_ll = 0;
   logic [3:0] h_dm, h_dl, m_dm, m_dl;
   logic h_pm, h_car, h_err, m_pm, m_car, m_err;
   int total = 0, bad = 0;
   int hc = 0, mc = 0;
   bit e_hcar = 0, e_herr = 0, e_mcar = 0, e_merr = 0;

   always #5 clk = ~clk;

   bcd_time_register #(.MAX_VALUE(23), .HOURS_MODE(1)) u_hours (
      .clk(clk), .reset_n(reset_n), .en(h_en), .dec(h_dec), .load(h_load),
      .load_msd(h_lm), .load_lsd(h_ll), .military_time(mil),
      .data_msd(h_dm), .data_lsd(h_dl), .pm(h_pm), .carry(h_car), .load_err(h_err));
   bcd_time_register #(.MAX_VALUE(59), .HOURS_MODE(0)) u_minutes (
      .clk(clk), .reset_n(reset_n), .en(m_en), .dec(m_dec), .load(m_load),
      .load_msd(m_lm), .load_lsd(m_ll), .military_time(mil),
      .data_msd(m_dm), .data_lsd(m_dl), .pm(m_pm), .carry(m_car), .load_err(m_err));

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void field_step(input int cnt, input int max, input bit ld, input int lm, input int ll,
                                      input bit inc, input bit dn, output int nc, output bit car, output bit err);
      int v = lm * 10 + ll;
      nc = cnt; car = 0; err = 0;
      if (!reset_n) nc = 0;
      else if (ld) begin
         if (ll <= 9 && v <= max) nc = v;
         else err = 1;
      end else if (inc) begin
         car = cnt == max;
         nc = (cnt + 1) % (max + 1);
      end else if (dn && DEC_ON) nc = (cnt + max) % (max + 1);
   endfunction

   function automatic int shown_hour(input int c, input bit m);
      return m ? c : (c % 12 == 0 ? 12 : c % 12);
   endfunction

   task automatic check_all();
      int d = shown_hour(hc, mil);
      check("h_msd", h_dm, d / 10);
      check("h_lsd", h_dl, d % 10);
      check("h_pm", h_pm, hc >= 12);
      check("h_carry", h_car, e_hcar);
      check("h_load_err", h_err, e_herr);
      check("m_msd", m_dm, mc / 10);
      check("m_lsd", m_dl, mc % 10);
      check("m_pm", m_pm, 0);
      check("m_carry", m_car, e_mcar);
      check("m_load_err", m_err, e_merr);
   endtask

   task automatic tick();
      @(posedge clk);
      field_step(hc, 23, h_load, h_lm, h_ll, h_en, h_dec, hc, e_hcar, e_herr);
      field_step(mc, 59, m_load, m_lm, m_ll, m_en, m_dec, mc, e_mcar, e_merr);
      #1;
      check_all();
   endtask

   task automatic idle();
      h_en = 0; h_dec = 0; h_load = 0; m_en = 0; m_dec = 0; m_load = 0;
   endtask

   initial begin
      #1;
      reset_n = 0;
      repeat (2) tick();
      reset_n = 1;
      repeat (10) tick();
      h_en = 1;
      repeat (24) tick();
      mil = 1;
      repeat (15) tick();
      mil = 0;
      #1;
      check_all();
      check("h_at_15", hc, 15);
      tick();
      mil = 1;
      repeat (8) tick();
      idle();
      m_load = 1; m_lm = 5; m_ll = 8;
      tick();
      m_load = 0; m_en = 1;
      repeat (3) tick();
      idle();
      mil = 0;
      h_load = 1; h_lm = 2; h_ll = 4;
      tick();
      h_lm = 1; h_ll = 4'hA;
      tick();
      h_lm = 2; h_ll = 3;
      tick();
      h_lm = 0; h_ll = 7; h_en = 1;
      tick();
      idle();
      m_load = 1; m_lm = 0; m_ll = 0;
      tick();
      m_load = 0; m_dec = 1;
      tick();
      m_dec = 0; m_load = 1; m_lm = 1; m_ll = 0;
      tick();
      m_load = 0; m_dec = 1;
      tick();
      m_en = 1;
      tick();
      idle();
      for (int i = 0; i < 600; i++) begin
         reset_n = ($urandom % 60) != 0;
         mil = $urandom % 2;
         h_load = ($urandom % 6) == 0; h_lm = 4'($urandom_range(0, 3)); h_ll = 4'($urandom_range(0, 11));
         m_load = ($urandom % 6) == 0; m_lm = 4'($urandom_range(0, 7)); m_ll = 4'($urandom_range(0, 11));
         h_en = $urandom % 2; h_dec = $urandom % 2;
         m_en = ($urandom % 3) != 0; m_dec = $urandom % 2;
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
